// File: rtl/rs232_tx_arbiter_if.sv
// Requester/transmitter handshake bundle for rs232_tx_arbiter.
// master = arbiter side, slave = requesters plus RS232 transmitter side.
interface rs232_tx_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]      req;
  logic [24*NREQ-1:0]   data;
  logic [NREQ-1:0]      ack;
  logic                 frame_done;
  logic                 ctrl_busy;
  logic                 tx_start;
  logic [7:0]           tx_byte;
  logic                 tx_busy;

  modport master (
    input  req, data, tx_busy,
    output ack, frame_done, ctrl_busy, tx_start, tx_byte
  );

  modport slave (
    output req, data, tx_busy,
    input  ack, frame_done, ctrl_busy, tx_start, tx_byte
  );
endinterface

// File: rtl/rs232_tx_arbiter.sv
// Round-robin sharing of one RS232 byte transmitter between NREQ record sources.
// Optional macro RS232_TX_ARB_ASCII_EN: 9-byte ASCII hex frame instead of the 4-byte raw frame.
module rs232_tx_arbiter #(
  parameter int         NREQ     = 2,
  parameter logic [7:0] TAG_BASE = 8'hA0
) (
  input  logic               clk,
  input  logic               rst_n,
  rs232_tx_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4
  } state_t;

`ifdef RS232_TX_ARB_ASCII_EN
  localparam logic [3:0] LAST_IDX = 4'd8;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10) begin
      hex_char = 8'h30 + {4'd0, nib};
    end else begin
      hex_char = 8'h37 + {4'd0, nib};
    end
  endfunction

  function automatic logic [7:0] frame_byte(input logic [3:0] bidx, input logic [23:0] rec,
                                            input logic [1:0] gidx);
    case (bidx)
      4'd0:    frame_byte = 8'h30 + {6'd0, gidx};
      4'd1:    frame_byte = hex_char(rec[23:20]);
      4'd2:    frame_byte = hex_char(rec[19:16]);
      4'd3:    frame_byte = hex_char(rec[15:12]);
      4'd4:    frame_byte = hex_char(rec[11:8]);
      4'd5:    frame_byte = hex_char(rec[7:4]);
      4'd6:    frame_byte = hex_char(rec[3:0]);
      4'd7:    frame_byte = 8'h0D;
      4'd8:    frame_byte = 8'h0A;
      default: frame_byte = 8'h00;
    endcase
  endfunction
`else
  localparam logic [3:0] LAST_IDX = 4'd3;

  function automatic logic [7:0] frame_byte(input logic [3:0] bidx, input logic [23:0] rec,
                                            input logic [1:0] gidx);
    case (bidx)
      4'd0:    frame_byte = TAG_BASE | {6'd0, gidx};
      4'd1:    frame_byte = rec[23:16];
      4'd2:    frame_byte = rec[15:8];
      4'd3:    frame_byte = rec[7:0];
      default: frame_byte = 8'h00;
    endcase
  endfunction
`endif

  state_t          state_r;
  logic [1:0]      last_grant_r;
  logic [1:0]      grant_idx_r;
  logic [3:0]      byte_idx_r;
  logic [23:0]     rec_r;
  logic [NREQ-1:0] ack_r;
  logic            frame_done_r;
  logic            ctrl_busy_r;
  logic            tx_start_r;
  logic [7:0]      tx_byte_r;

  logic [3:0]      req_pad_s;
  logic [95:0]     data_pad_s;
  logic [2:0]      cand_s;
  logic            grant_found_s;
  logic [1:0]      grant_idx_s;
  logic [23:0]     grant_rec_s;
  logic [3:0]      grant_onehot_s;

  // Round-robin search: start one past the last grant, wrap, first asserted request wins.
  always_comb begin
    req_pad_s                  = 4'd0;
    req_pad_s[NREQ-1:0]        = bus.req;
    data_pad_s                 = 96'd0;
    data_pad_s[24*NREQ-1:0]    = bus.data;
    cand_s                     = 3'd0;
    grant_found_s              = 1'b0;
    grant_idx_s                = 2'd0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = {1'b0, last_grant_r} + 3'(k);
      cand_s = (cand_s >= 3'(NREQ)) ? (cand_s - 3'(NREQ)) : cand_s;
      if (!grant_found_s && req_pad_s[cand_s[1:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s[1:0];
      end else begin
        grant_idx_s   = grant_idx_s;
      end
    end
    case (grant_idx_s)
      2'd0:    grant_rec_s = data_pad_s[23:0];
      2'd1:    grant_rec_s = data_pad_s[47:24];
      2'd2:    grant_rec_s = data_pad_s[71:48];
      2'd3:    grant_rec_s = data_pad_s[95:72];
      default: grant_rec_s = 24'd0;
    endcase
    grant_onehot_s = 4'b0001 << grant_idx_s;
  end

  // Frame sequencer; strobes are set on the transition into the state that owns them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= 2'd0;
      grant_idx_r  <= 2'd0;
      byte_idx_r   <= 4'd0;
      rec_r        <= 24'd0;
      ack_r        <= {NREQ{1'b0}};
      frame_done_r <= 1'b0;
      ctrl_busy_r  <= 1'b0;
      tx_start_r   <= 1'b0;
      tx_byte_r    <= 8'd0;
    end else begin
      ack_r        <= {NREQ{1'b0}};
      frame_done_r <= 1'b0;
      tx_start_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          // The transmitter has no reset, so a byte may still be in flight here.
          if (grant_found_s && !bus.tx_busy) begin
            rec_r       <= grant_rec_s;
            grant_idx_r <= grant_idx_s;
            ack_r       <= grant_onehot_s[NREQ-1:0];
            ctrl_busy_r <= 1'b1;
            byte_idx_r  <= 4'd0;
            tx_byte_r   <= frame_byte(4'd0, grant_rec_s, grant_idx_s);
            tx_start_r  <= 1'b1;
            state_r     <= START;
          end else begin
            state_r     <= IDLE;
          end
        end
        START: begin
          state_r <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state_r <= WAIT_DONE;
          end else begin
            state_r <= WAIT_BUSY;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            if (byte_idx_r < LAST_IDX) begin
              byte_idx_r <= byte_idx_r + 4'd1;
              tx_byte_r  <= frame_byte(byte_idx_r + 4'd1, rec_r, grant_idx_r);
              tx_start_r <= 1'b1;
              state_r    <= START;
            end else begin
              frame_done_r <= 1'b1;
              state_r      <= DONE;
            end
          end else begin
            state_r <= WAIT_DONE;
          end
        end
        DONE: begin
          ctrl_busy_r  <= 1'b0;
          last_grant_r <= grant_idx_r;
          state_r      <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack        = ack_r;
  assign bus.frame_done = frame_done_r;
  assign bus.ctrl_busy  = ctrl_busy_r;
  assign bus.tx_start   = tx_start_r;
  assign bus.tx_byte    = tx_byte_r;

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Self-checking bench for rs232_tx_arbiter (NREQ=2): transmitter model, frame/grant
// reference model, per-cycle compare, directed scenarios and a randomized phase.
module tb_rs232_tx_arbiter;

`ifdef RS232_TX_ARB_ASCII_EN
  localparam bit ASCII = 1'b1;
`else
  localparam bit ASCII = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rs232_tx_arbiter_if #(.NREQ(2)) bus ();

  rs232_tx_arbiter #(.NREQ(2), .TAG_BASE(8'hA0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // transmitter model: busy 'lat' cycles after the start strobe, for 'dur' cycles
  int   lat = 1;
  int   dur = 40;
  int   wait_cnt = 0;
  int   busy_cnt = 0;
  logic tx_busy_m = 1'b0;
  assign bus.tx_busy = tx_busy_m;

  always @(posedge clk) begin
    if (bus.tx_start) begin
      if (lat <= 1) begin
        tx_busy_m <= 1'b1;
        busy_cnt  <= dur;
        wait_cnt  <= 0;
      end else begin
        wait_cnt  <= lat - 1;
      end
    end else if (wait_cnt > 0) begin
      wait_cnt <= wait_cnt - 1;
      if (wait_cnt == 1) begin
        tx_busy_m <= 1'b1;
        busy_cnt  <= dur;
      end
    end else if (tx_busy_m) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt <= 1) tx_busy_m <= 1'b0;
    end
  end

  // inputs as seen by the DUT at each rising edge
  logic [1:0]  req_q = 2'b00;
  logic [47:0] data_q = 48'd0;
  logic        busy_q = 1'b0;
  logic        rstn_q = 1'b0;
  always @(posedge clk) begin
    req_q  <= bus.req;
    data_q <= bus.data;
    busy_q <= tx_busy_m;
    rstn_q <= rst_n;
  end

  // reference model state
  bit         in_frame = 0, prev_done = 0, busy_seen = 0, started = 0;
  int         m_last = 0;
  int         frames_done = 0;
  int         acks [2] = '{0, 0};
  logic [7:0] exp_q[$];
  logic [7:0] frame_tmp[$];
  logic [7:0] log_q[$];
  logic [7:0] exp_lit[$];
  int         grant_log[$];

  function automatic int winner(input logic [1:0] r, input int last);
    int i;
    for (int k = 1; k <= 2; k++) begin
      i = (last + k) % 2;
      if (r[i]) return i;
    end
    return 0;
  endfunction

  function automatic void mk_frame(input int w, input logic [23:0] rec);
    int nib;
    frame_tmp.delete();
    if (ASCII) begin
      frame_tmp.push_back(8'(8'h30 + w));
      for (int n = 5; n >= 0; n--) begin
        nib = int'((rec >> (4 * n)) & 24'hF);
        frame_tmp.push_back(nib < 10 ? 8'(8'h30 + nib) : 8'(8'h41 + nib - 10));
      end
      frame_tmp.push_back(8'h0D);
      frame_tmp.push_back(8'h0A);
    end else begin
      frame_tmp.push_back(8'(8'hA0 + w));
      frame_tmp.push_back(rec[23:16]);
      frame_tmp.push_back(rec[15:8]);
      frame_tmp.push_back(rec[7:0]);
    end
  endfunction

  // per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    logic [1:0] exp_ack;
    int         w;
    bit         hs_done, exp_start, exp_done;
    if (!rst_n) begin
      check("rst_ack", 32'(bus.ack), 32'd0);
      check("rst_frame_done", 32'(bus.frame_done), 32'd0);
      check("rst_ctrl_busy", 32'(bus.ctrl_busy), 32'd0);
      check("rst_tx_start", 32'(bus.tx_start), 32'd0);
      check("rst_tx_byte", 32'(bus.tx_byte), 32'd0);
      in_frame = 0; prev_done = 0; busy_seen = 0; started = 0; m_last = 0;
      exp_q.delete();
    end else begin
      exp_ack = 2'b00;
      w = 0;
      if (rstn_q && !in_frame && !prev_done && req_q != 2'b00 && !busy_q) begin
        w = winner(req_q, m_last);
        exp_ack = 2'(2'b01 << w);
      end
      hs_done   = in_frame && started && busy_seen && !busy_q;
      exp_start = (exp_ack != 2'b00) || (hs_done && exp_q.size() > 0);
      exp_done  = hs_done && exp_q.size() == 0;
      check("ack", 32'(bus.ack), 32'(exp_ack));
      check("tx_start", 32'(bus.tx_start), 32'(exp_start));
      check("frame_done", 32'(bus.frame_done), 32'(exp_done));
      if (exp_ack != 2'b00) begin
        in_frame = 1;
        m_last = w;
        acks[w]++;
        grant_log.push_back(w);
        mk_frame(w, (w == 0) ? data_q[23:0] : data_q[47:24]);
        exp_q = frame_tmp;
        started = 0;
      end
      prev_done = 0;
      if (bus.tx_start) begin
        check("start_while_busy", 32'(tx_busy_m), 32'd0);
        log_q.push_back(bus.tx_byte);
      end
      if (exp_start && exp_q.size() > 0) begin
        check("tx_byte", 32'(bus.tx_byte), 32'(exp_q[0]));
        void'(exp_q.pop_front());
        started = 1;
        busy_seen = 0;
      end
      check("ctrl_busy", 32'(bus.ctrl_busy), 32'(in_frame));
      if (exp_done) begin
        in_frame = 0;
        prev_done = 1;
        started = 0;
        frames_done++;
      end
      if (tx_busy_m) busy_seen = 1;
    end
  end

  task automatic cmp_log(input string name);
    check({name, "_len"}, 32'(log_q.size()), 32'(exp_lit.size()));
    for (int i = 0; i < exp_lit.size() && i < log_q.size(); i++)
      check(name, 32'(log_q[i]), 32'(exp_lit[i]));
  endtask

  task automatic wait_ack(input int idx, input string name);
    int n0 = acks[idx];
    int cyc = 0;
    while (acks[idx] == n0 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, "_ack_seen"}, 32'(acks[idx] - n0), 32'd1);
  endtask

  task automatic wait_frames(input int target, input string name);
    int cyc = 0;
    while (frames_done < target && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, "_frame_done"}, 32'(frames_done), 32'(target));
  endtask

  task automatic send_one(input int idx, input logic [23:0] rec, input string name);
    int f0 = frames_done;
    if (idx == 0) bus.data[23:0] = rec;
    else          bus.data[47:24] = rec;
    log_q.delete();
    bus.req[idx] = 1'b1;
    wait_ack(idx, name);
    bus.req[idx] = 1'b0;
    wait_frames(f0 + 1, name);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int f0, a0;
    bus.req  = 2'b00;
    bus.data = 48'd0;

    // pin the frame model to hand-computed bytes
    mk_frame(1, 24'h00F09C);
    if (ASCII) exp_lit = '{8'h31, 8'h30, 8'h30, 8'h46, 8'h30, 8'h39, 8'h43, 8'h0D, 8'h0A};
    else       exp_lit = '{8'hA1, 8'h00, 8'hF0, 8'h9C};
    check("model_len", 32'(frame_tmp.size()), 32'(exp_lit.size()));
    for (int i = 0; i < exp_lit.size() && i < frame_tmp.size(); i++)
      check("model_byte", 32'(frame_tmp[i]), 32'(exp_lit[i]));

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // single requester, nominal transmitter
    lat = 1; dur = 40;
    a0 = acks[0];
    send_one(0, 24'h12AB34, "basic");
    if (ASCII) exp_lit = '{8'h30, 8'h31, 8'h32, 8'h41, 8'h42, 8'h33, 8'h34, 8'h0D, 8'h0A};
    else       exp_lit = '{8'hA0, 8'h12, 8'hAB, 8'h34};
    cmp_log("basic_bytes");
    check("basic_ack_once", 32'(acks[0] - a0), 32'd1);

    // both requesting: strict alternation starting with requester 1
    lat = 1; dur = 6;
    grant_log.delete();
    bus.data = {24'h111111, 24'h000000};
    bus.req = 2'b11;
    begin
      int cyc = 0;
      while (grant_log.size() < 4 && cyc < 2000) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    bus.req = 2'b00;
    f0 = frames_done;
    wait_frames(f0 + 1, "rr");
    check("rr_count", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check("rr_order", 32'(grant_log[i]), 32'((i % 2 == 0) ? 1 : 0));

    // requester 1 record from the test plan
    send_one(1, 24'h00F09C, "req1");
    if (ASCII) exp_lit = '{8'h31, 8'h30, 8'h30, 8'h46, 8'h30, 8'h39, 8'h43, 8'h0D, 8'h0A};
    else       exp_lit = '{8'hA1, 8'h00, 8'hF0, 8'h9C};
    cmp_log("req1_bytes");

    // record changes after ack must not leak into the frame
    f0 = frames_done;
    log_q.delete();
    bus.data[23:0] = 24'h000001;
    bus.req[0] = 1'b1;
    wait_ack(0, "hold");
    bus.req[0] = 1'b0;
    bus.data[23:0] = 24'hFFFFFF;
    wait_frames(f0 + 1, "hold");
    if (ASCII) exp_lit = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h31, 8'h0D, 8'h0A};
    else       exp_lit = '{8'hA0, 8'h00, 8'h00, 8'h01};
    cmp_log("hold_bytes");

    // reset while the transmitter is busy with the second byte
    lat = 1; dur = 40;
    log_q.delete();
    bus.data[23:0] = 24'h123456;
    bus.req[0] = 1'b1;
    begin
      int cyc = 0;
      while (log_q.size() < 2 && cyc < 500) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_scenario_busy", 32'(tx_busy_m), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_now_ctrl_busy", 32'(bus.ctrl_busy), 32'd0);
    check("rst_now_tx_byte", 32'(bus.tx_byte), 32'd0);
    check("rst_now_ack", 32'(bus.ack), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    log_q.delete();
    f0 = frames_done;
    wait_ack(0, "post_rst");
    bus.req[0] = 1'b0;
    wait_frames(f0 + 1, "post_rst");
    check("post_rst_len", 32'(log_q.size()), ASCII ? 32'd9 : 32'd4);
    if (log_q.size() > 0)
      check("post_rst_tag", 32'(log_q[0]), ASCII ? 32'h30 : 32'hA0);

    // slow transmitter: busy rises three cycles after the strobe
    lat = 3; dur = 5;
    send_one(1, 24'hC0FFEE, "slow");
    if (ASCII) exp_lit = '{8'h31, 8'h43, 8'h30, 8'h46, 8'h46, 8'h45, 8'h45, 8'h0D, 8'h0A};
    else       exp_lit = '{8'hA1, 8'hC0, 8'hFF, 8'hEE};
    cmp_log("slow_bytes");

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (bus.ack[i])                                 bus.req[i] = ($urandom_range(0, 3) == 0);
        else if (!bus.req[i] && $urandom_range(0, 7) == 0) bus.req[i] = 1'b1;
        else if (bus.req[i] && $urandom_range(0, 31) == 0) bus.req[i] = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) bus.data = {24'($urandom), 24'($urandom)};
      lat = $urandom_range(1, 3);
      dur = $urandom_range(1, 8);
    end
    bus.req = 2'b00;
    begin
      int cyc = 0;
      while (in_frame && cyc < 2000) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    repeat (4) @(posedge clk);
    #1;
    check("drain_ctrl_busy", 32'(bus.ctrl_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
